// File: rtl/uop_queue_mw.sv
// ----------------------------------------------------------------------------
// uop_queue_mw
//   Multi-width circular micro-op queue sitting between the decoder/cracker
//   and rename. Up to ENQ_W uops are written per cycle at the tail, and the
//   oldest DEQ_W entries are always presented at the head. Requested
//   enqueue/dequeue counts are clamped internally, and the accepted counts
//   are reported back as grants. Supports full flush and youngest-N squash
//   (tail rollback). Full/empty are derived from the occupancy counter only.
//
// Ports
//   clk_in         clock, all state on rising edge
//   rst_N_in       asynchronous active-low reset
//   flush_in       discard all entries (highest priority)
//   squash_in      discard youngest squash_cnt_in entries
//   squash_cnt_in  number of entries to squash (clamped to count)
//   enq_cnt_in     uops offered; enq_data_in slots 0..enq_cnt_in-1 valid
//   enq_data_in    offered uops, slot 0 oldest
//   deq_cnt_in     uops requested to pop
//   enq_grant_out  uops accepted this cycle (combinational)
//   deq_grant_out  uops popped this cycle (combinational)
//   deq_data_out   entries head..head+DEQ_W-1, slot 0 oldest
//   deq_valid_out  bit i set iff i < count
//   count_out      occupancy
//   free_out       DEPTH - count
//   full_out       count == DEPTH
//   empty_out      count == 0
// ----------------------------------------------------------------------------
module uop_queue_mw #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    parameter int ENQ_W  = 4,
    parameter int DEQ_W  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int ENQ_CW = $clog2(ENQ_W + 1),
    localparam int DEQ_CW = $clog2(DEQ_W + 1)
) (
    input  logic                    clk_in,
    input  logic                    rst_N_in,
    input  logic                    flush_in,
    input  logic                    squash_in,
    input  logic [CNT_W-1:0]        squash_cnt_in,
    input  logic [ENQ_CW-1:0]       enq_cnt_in,
    input  logic [ENQ_W*DATA_W-1:0] enq_data_in,
    input  logic [DEQ_CW-1:0]       deq_cnt_in,
    output logic [ENQ_CW-1:0]       enq_grant_out,
    output logic [DEQ_CW-1:0]       deq_grant_out,
    output logic [DEQ_W*DATA_W-1:0] deq_data_out,
    output logic [DEQ_W-1:0]        deq_valid_out,
    output logic [CNT_W-1:0]        count_out,
    output logic [CNT_W-1:0]        free_out,
    output logic                    full_out,
    output logic                    empty_out
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    // All grant arithmetic is done at counter width so that comparisons
    // against count/free never lose bits.
    logic [CNT_W-1:0] enq_req;
    logic [CNT_W-1:0] deq_req;
    logic [CNT_W-1:0] room;
    logic [CNT_W-1:0] avail;
    logic [CNT_W-1:0] sq;
    logic [CNT_W-1:0] enq_g;
    logic [CNT_W-1:0] deq_g;

    // ------------------------------------------------------------------
    // Grant computation
    // ------------------------------------------------------------------
    always_comb begin
        enq_req = CNT_W'(enq_cnt_in);
        deq_req = CNT_W'(deq_cnt_in);
        room    = CNT_W'(DEPTH) - count;
        avail   = count;
        sq      = '0;
        enq_g   = '0;
        deq_g   = '0;

        // Grants are forced to zero while reset is asserted so that the
        // producer/consumer never see an acceptance that will not happen.
        if (rst_N_in && !flush_in) begin
            if (squash_in) begin
                sq    = (squash_cnt_in < count) ? squash_cnt_in : count;
                avail = count - sq;
                deq_g = (deq_req < avail) ? deq_req : avail;
            end else begin
                // Room is based on start-of-cycle count; a same-cycle pop
                // does not make space, and a same-cycle push cannot be popped.
                enq_g = (enq_req < room)  ? enq_req : room;
                deq_g = (deq_req < count) ? deq_req : count;
            end
        end

        enq_grant_out = ENQ_CW'(enq_g);
        deq_grant_out = DEQ_CW'(deq_g);
    end

    // ------------------------------------------------------------------
    // Pointer / occupancy state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // Pointer arithmetic wraps modulo DEPTH; squashing rolls the
            // tail back, possibly below zero.
            head  <= head + PTR_W'(deq_g);
            tail  <= tail + PTR_W'(enq_g) - PTR_W'(sq);
            count <= count + enq_g - deq_g - sq;
        end
    end

    // ------------------------------------------------------------------
    // Storage: only granted slots are written, no reset needed
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        for (int unsigned i = 0; i < ENQ_W; i++) begin
            if (i < 32'(enq_g)) begin
                mem[tail + PTR_W'(i)] <= enq_data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Head window and status, from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        deq_data_out  = '0;
        deq_valid_out = '0;
        for (int unsigned i = 0; i < DEQ_W; i++) begin
            deq_data_out[i*DATA_W +: DATA_W] = mem[head + PTR_W'(i)];
            deq_valid_out[i]                 = (i < 32'(count));
        end
    end

    assign count_out = count;
    assign free_out  = CNT_W'(DEPTH) - count;
    assign full_out  = (count == CNT_W'(DEPTH));
    assign empty_out = (count == '0);

endmodule
